// File: rtl/xil_bram_tdp_arb_if.sv
// Requester, RAM-port, response and clear-control bundle for xil_bram_tdp_arb.
// master = requesters plus the RAM (read data); slave = the arbiter.
interface xil_bram_tdp_arb_if #(
    parameter int ADR  = 10,
    parameter int DAT  = 18,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]     req_vld;
    logic [NREQ-1:0]     req_wen;
    logic [NREQ*ADR-1:0] req_adr;
    logic [NREQ*DAT-1:0] req_wda;
    logic [NREQ-1:0]     req_rdy;
    logic [ADR-1:0]      adra, adrb;
    logic                wena, wenb;
    logic                rena, renb;
    logic [DAT-1:0]      wdaa, wdab;
    logic [DAT-1:0]      rdaa, rdab;
    logic                rspa_vld, rspb_vld;
    logic [IDW-1:0]      rspa_id, rspb_id;
    logic [DAT-1:0]      rspa_dat, rspb_dat;
    logic                clr_start;
    logic                clr_busy;

    modport master (
        output req_vld, req_wen, req_adr, req_wda, rdaa, rdab, clr_start,
        input  req_rdy, adra, adrb, wena, wenb, rena, renb, wdaa, wdab,
               rspa_vld, rspb_vld, rspa_id, rspb_id, rspa_dat, rspb_dat, clr_busy
    );
    modport slave (
        input  req_vld, req_wen, req_adr, req_wda, rdaa, rdab, clr_start,
        output req_rdy, adra, adrb, wena, wenb, rena, renb, wdaa, wdab,
               rspa_vld, rspb_vld, rspa_id, rspb_id, rspa_dat, rspb_dat, clr_busy
    );
endinterface

// File: rtl/xil_bram_tdp_arb.sv
// Round-robin two-port arbiter and zero-fill sequencer for a single-clock TDP BRAM.
// Grants reach the RAM pins combinationally; read responses follow DEL cycles later; losers simply see req_rdy=0.
module xil_bram_tdp_arb #(
    parameter int ADR    = 10,
    parameter int DAT    = 18,
    parameter int DEP    = 1024,
    parameter int DEL    = 1,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int CLR_EN = 1
) (
    input  logic             clka,
    input  logic             rsta,
    xil_bram_tdp_arb_if.slave bus
);
    localparam int NSL = 1 << IDW;

    typedef enum logic [1:0] {ST_INIT, ST_CLR, ST_RUN} state_t;

    state_t         state, state_nx;
    logic [ADR-1:0] clr_cnt, clr_cnt_nx;
    logic [IDW-1:0] rr_ptr, rr_nx;

    // Requests padded to a power-of-two table so IDW-wide indices always land in range.
    logic [NSL-1:0] vld_p, wen_p;
    logic [ADR-1:0] adr_p [NSL];
    logic [DAT-1:0] wda_p [NSL];

    always_comb begin
        vld_p = '0;
        wen_p = '0;
        for (int i = 0; i < NSL; i++) begin
            adr_p[i] = '0;
            wda_p[i] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            vld_p[i] = bus.req_vld[i];
            wen_p[i] = bus.req_wen[i];
            adr_p[i] = bus.req_adr[i*ADR +: ADR];
            wda_p[i] = bus.req_wda[i*DAT +: DAT];
        end
    end

    logic           ga_v, gb_v;
    logic [IDW-1:0] ga, gb, last, idx;
    logic [IDW:0]   sum, nxt;

    always_comb begin
        ga_v = 1'b0;
        gb_v = 1'b0;
        ga   = '0;
        gb   = '0;
        last = rr_ptr;
        sum  = '0;
        idx  = '0;
        nxt  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            idx = sum[IDW-1:0];
            if (vld_p[idx]) begin
                if (!ga_v) begin
                    ga_v = 1'b1;
                    ga   = idx;
                    last = idx;
                end else if (!gb_v && !((adr_p[idx] == adr_p[ga]) && (wen_p[idx] || wen_p[ga]))) begin
                    // Conflicting requesters are skipped, not blocking the scan.
                    gb_v = 1'b1;
                    gb   = idx;
                    last = idx;
                end
            end
        end
        nxt = {1'b0, last} + 1'b1;
        rr_nx = (nxt >= (IDW+1)'(NREQ)) ? '0 : nxt[IDW-1:0];
    end

    logic [NSL-1:0] rdy_p;
    logic [ADR-1:0] adra_c, adrb_c;
    logic [DAT-1:0] wdaa_c, wdab_c;
    logic           wena_c, wenb_c, rena_c, renb_c;
    logic           gnt_any;

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        rdy_p      = '0;
        adra_c     = '0;
        adrb_c     = '0;
        wdaa_c     = '0;
        wdab_c     = '0;
        wena_c     = 1'b0;
        wenb_c     = 1'b0;
        rena_c     = 1'b0;
        renb_c     = 1'b0;
        gnt_any    = 1'b0;
        case (state)
            ST_INIT: state_nx = (CLR_EN != 0) ? ST_CLR : ST_RUN;
            ST_CLR: begin
                wena_c = 1'b1;
                adra_c = clr_cnt;
                if (clr_cnt == ADR'(DEP-1)) begin
                    state_nx   = ST_RUN;
                    clr_cnt_nx = '0;
                end else begin
                    clr_cnt_nx = clr_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (ga_v) begin
                    gnt_any   = 1'b1;
                    rdy_p[ga] = 1'b1;
                    wena_c    = wen_p[ga];
                    rena_c    = ~wen_p[ga];
                    adra_c    = adr_p[ga];
                    wdaa_c    = wda_p[ga];
                end
                if (gb_v) begin
                    rdy_p[gb] = 1'b1;
                    wenb_c    = wen_p[gb];
                    renb_c    = ~wen_p[gb];
                    adrb_c    = adr_p[gb];
                    wdab_c    = wda_p[gb];
                end
                // This cycle's grants still go out; the clear starts at the next edge.
                if (bus.clr_start && (CLR_EN != 0))
                    state_nx = ST_CLR;
            end
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
            if (gnt_any)
                rr_ptr <= rr_nx;
        end
    end

    logic [DEL-1:0] va_sh, vb_sh;
    logic [IDW-1:0] ia_sh [DEL];
    logic [IDW-1:0] ib_sh [DEL];

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            va_sh <= '0;
            vb_sh <= '0;
            for (int i = 0; i < DEL; i++) begin
                ia_sh[i] <= '0;
                ib_sh[i] <= '0;
            end
        end else begin
            va_sh[0] <= rena_c;
            vb_sh[0] <= renb_c;
            ia_sh[0] <= rena_c ? ga : '0;
            ib_sh[0] <= renb_c ? gb : '0;
            for (int i = 1; i < DEL; i++) begin
                va_sh[i] <= va_sh[i-1];
                vb_sh[i] <= vb_sh[i-1];
                ia_sh[i] <= ia_sh[i-1];
                ib_sh[i] <= ib_sh[i-1];
            end
        end
    end

    assign bus.req_rdy  = rdy_p[NREQ-1:0];
    assign bus.adra     = adra_c;
    assign bus.adrb     = adrb_c;
    assign bus.wena     = wena_c;
    assign bus.wenb     = wenb_c;
    assign bus.rena     = rena_c;
    assign bus.renb     = renb_c;
    assign bus.wdaa     = wdaa_c;
    assign bus.wdab     = wdab_c;
    assign bus.rspa_vld = va_sh[DEL-1];
    assign bus.rspb_vld = vb_sh[DEL-1];
    assign bus.rspa_id  = ia_sh[DEL-1];
    assign bus.rspb_id  = ib_sh[DEL-1];
    assign bus.rspa_dat = bus.rdaa;
    assign bus.rspb_dat = bus.rdab;
    assign bus.clr_busy = (state != ST_RUN);

endmodule

// File: doc/xil_bram_tdp_arb.md
# xil_bram_tdp_arb

Request arbiter and clear sequencer for one single-clock true-dual-port block RAM (`xil_bram_tdp_1clk_wrap`-class memory). It accepts up to NREQ independent read/write requesters. Each cycle it grants at most two of them onto RAM ports A and B, using round-robin priority with same-address hazard blocking. Read data returns with the requester ID attached. After reset, and on command, it zero-fills the whole RAM before normal traffic is allowed.

## Interface
Parameters:
- ADR, 10, RAM address width
- DAT, 18, RAM data width
- DEP, 1024, RAM depth; clear range is 0..DEP-1
- DEL, 1, RAM read latency in cycles from ren to valid rdat (DEL >= 1)
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width (2^IDW >= NREQ)
- CLR_EN, 1, 1 = clear after reset and on clr_start; 0 = no clear engine

Ports:
- clka  in  1  clock; single clock for the block and the RAM
- rsta  in  1  reset, asynchronous, active-high
- req_vld  in  NREQ  request valid per requester
- req_wen  in  NREQ  1 = write, 0 = read
- req_adr  in  NREQ*ADR  packed addresses; requester i uses [i*ADR +: ADR]
- req_wda  in  NREQ*DAT  packed write data
- req_rdy  out  NREQ  grant; a transfer occurs when req_vld & req_rdy
- adra, adrb  out  ADR  RAM address, ports A/B
- wena, wenb  out  1  RAM write enable
- rena, renb  out  1  RAM read enable
- wdaa, wdab  out  DAT  RAM write data
- rdaa, rdab  in  DAT  RAM read data
- rspa_vld, rspb_vld  out  1  read response valid, per port
- rspa_id, rspb_id  out  IDW  requester ID of the response
- rspa_dat, rspb_dat  out  DAT  response data; equal to rdaa/rdab
- clr_start  in  1  single-cycle pulse; starts a clear while in RUN
- clr_busy  out  1  high while in INIT or CLR

## Operation
- FSM has three states: INIT, CLR and RUN. Reset puts it in INIT.
  - INIT -> CLR when CLR_EN=1; INIT -> RUN when CLR_EN=0. INIT always lasts exactly one cycle.
  - CLR: clr_cnt starts at 0. Each cycle drives wena=1, adra=clr_cnt, wdaa=0, then increments clr_cnt. In the cycle where clr_cnt=DEP-1, the FSM moves to RUN.
  - RUN -> CLR on clr_start when CLR_EN=1. clr_start is ignored in INIT, in CLR, and whenever CLR_EN=0.
- In INIT and CLR: req_rdy=0, wenb=renb=rena=0.
- RUN arbitration is combinational from req_vld, req_wen, req_adr and the registered pointer rr_ptr.
  - Scan requesters in order rr_ptr, rr_ptr+1, … (mod NREQ).
  - The first valid requester gets port A.
  - The next valid requester gets port B, provided it does not conflict with the port A request.
  - Conflict = same address and at least one of the two is a write. A conflicting requester is skipped and the scan continues; it stays pending.
  - A read-read pair to the same address is allowed.
- Port drive: wenx=req_wen, renx=~req_wen, adrx/wdax from the granted requester. An idle port has wen=ren=0, and adr/wda hold 0.
- rr_ptr update on any grant: rr_ptr <= (highest-scanned granted index + 1) mod NREQ. With no grants, rr_ptr holds. Reset value is 0.
- Requesters hold their request stable until granted. The block does not store requests.
- Response path: per port, a DEL-stage shift register of {valid, id}. It loads {renx, granted id} and drives rspx_vld and rspx_id.
  - The pipeline runs in every state. Reads already issued before clr_start still return.
  - Write grants produce no response.

## Timing
- Reset values: req_rdy=0, all enables 0, adr/wda 0, rsp*_vld=0, rsp*_id=0, clr_busy=1, rr_ptr=0, clr_cnt=0.
- Grant and RAM command are issued in the same cycle (0 cycles from a valid request to the RAM pins).
- Read response: rspx_vld is high exactly DEL cycles after the cycle where renx=1, aligned with valid rdax.
- Clear timing (CLR_EN=1): the first rising edge after rsta deasserts is INIT. The next DEP cycles are CLR. The first possible grant is in cycle DEP+1. clr_busy falls in that same cycle.
- A clr_start in RUN moves the FSM to CLR at the next edge. The grants in the clr_start cycle still execute.
- Throughput: up to 2 transfers per cycle. Any continuously valid requester is granted within NREQ cycles.

## Test plan
- Reset release with DEP=16, CLR_EN=1 -> one INIT cycle, then 16 cycles of wena=1 with adra 0..15 and wdaa=0. clr_busy=0 from cycle 17, and no req_rdy before that.
- All 4 requesters read distinct addresses, DEL=1, rr_ptr=0 -> cycle 0 grants 0 (A) and 1 (B); cycle 1 grants 2 and 3. Responses appear one cycle later with IDs 0,1 then 2,3.
- Requester 0 writes 0x5 and requester 1 writes 0x9, both at address 3 -> only requester 0 is granted. Requester 1 is granted next cycle. A later read of address 3 returns 0x9.
- Requesters 0 and 1 read address 7 in the same cycle -> both granted; both responses carry the same data.
- Requester 2 is held valid continuously while 0, 1 and 3 are also valid -> requester 2 is granted within 2 cycles. rr_ptr advances as specified.
- A read is issued in the same cycle as clr_start (DEL=2) -> the read response arrives 2 cycles later while clr_busy=1. CLR then runs for DEP cycles, and req_rdy=0 throughout.
